program_counter_stack: RTL and testbench
========================================

Name: program_counter_stack

Overview:
Parametrised successor to the single-width program counter. Adds relative branch, hardware call/return via an internal return-address LIFO, and sticky overflow/underflow error flags. Sits in the CPU fetch path and drives the instruction-memory address. All state updates on the falling edge of clk, consistent with the CPU datapath.

Parameters:
WIDTH, 16, PC and address width in bits (min 4)
DEPTH, 8, return-stack entries (power of 2, min 2)
RESET_VECTOR, 0, PC value after reset
TRAP_VECTOR, 16'h7FF0, PC target on stack error (only with PC_TRAP_EN); truncated to WIDTH

Ports:
clk  in  1  clock; all state changes on negedge
reset  in  1  synchronous, active-low (0 = reset), sampled on negedge clk
in_value  in  WIDTH  absolute target for load and call
offset  in  WIDTH  two's-complement branch offset
load  in  1  absolute jump
call  in  1  push PC+1, jump to in_value
ret  in  1  pop return address into PC
branch  in  1  PC <= PC + offset
increment  in  1  PC <= PC + 1
clear_err  in  1  clears sticky error flags
out  out  WIDTH  current PC
depth  out  $clog2(DEPTH)+1  valid stack entries
full  out  1  depth == DEPTH
empty  out  1  depth == 0
overflow  out  1  sticky: call attempted while full
underflow  out  1  sticky: ret attempted while empty

Behaviour:
- Reset (reset==0 at negedge): out=RESET_VECTOR, depth=0, overflow=0, underflow=0, full=0, empty=1. Stack contents don't-care. Reset overrides every other input, including mid call/ret sequences.
- Single-cycle operation; out reflects the new value immediately after the negedge. No internal pipeline.
- Priority when several controls are high: load > call > ret > branch > increment > hold. Only the highest-priority action takes effect; lower-priority requests in the same cycle are dropped, not queued.
- Arithmetic is modulo 2^WIDTH. PC+1 wraps from all-ones to 0. PC+offset wraps silently with no flag.
- call, not full: stack[depth] <= out+1 (wrapped); depth++; out <= in_value.
- call, full: stack and depth unchanged; overflow <= 1; out <= in_value (without PC_TRAP_EN).
- ret, not empty: out <= stack[depth-1]; depth--.
- ret, empty: out unchanged; underflow <= 1 (without PC_TRAP_EN).
- load, branch, increment: stack untouched.
- clear_err clears both flags on the next negedge. If an error occurs in the same cycle, the new error wins and the flag stays set.
- full and empty are combinational decodes of depth.

Optional Feature:
PC_TRAP_EN
- Defined: an overflowing call or underflowing ret loads out <= TRAP_VECTOR instead of the normal target. Stack is unchanged and the flag is still set.
- Undefined: behaviour exactly as in Behaviour above; TRAP_VECTOR is unused.

Decomposition:
- Package pc_pkg holds:
  - pc_op_t enum {OP_HOLD, OP_INC, OP_BRANCH, OP_RET, OP_CALL, OP_LOAD};
  - a function that priority-encodes the control bits to pc_op_t;
  - a DEPTH_W localparam helper.
- Sub-module return_stack: a LIFO with push, pop, push_data, top, depth, full and empty. It has no error logic.
- The top level owns the PC register, priority decode, error flags and trap mux.

Test Plan:
1. Reset low one cycle, then increment ×3 -> out = 0,1,2,3; empty=1, depth=0.
2. out=0x0010, call in_value=0x0100 -> out=0x0100, depth=1. Then call 0x0200 -> depth=2. ret -> out=0x0101. ret -> out=0x0011, empty=1.
3. DEPTH=8: issue 9 calls -> after the 8th, full=1. The 9th sets overflow=1, depth stays 8, out=target (or TRAP_VECTOR with PC_TRAP_EN). clear_err -> overflow=0.
4. ret while empty at out=0x0042 -> underflow=1, out stays 0x0042 (or TRAP_VECTOR with PC_TRAP_EN).
5. out=0x0005, branch offset=0xFFFD -> out=0x0002. Then out=0xFFFF, increment -> out=0x0000.
6. load, call and increment all high with in_value=0x1234 -> out=0x1234, depth unchanged. Then assert reset mid-stack (depth=3) -> out=RESET_VECTOR, depth=0, flags 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and helpers for program_counter_stack and its return stack.
package pc_pkg;

  // One action per cycle, listed from lowest to highest priority.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_BRANCH,
    OP_RET,
    OP_CALL,
    OP_LOAD
  } pc_op_t;

  // Width of an occupancy count that must represent 0..entries inclusive.
  function automatic int depth_w(input int entries);
    return $clog2(entries) + 1;
  endfunction

  // Priority encode: load > call > ret > branch > increment > hold.
  // Lower-priority requests raised in the same cycle are simply dropped.
  function automatic pc_op_t pc_decode(
    input logic load,
    input logic call,
    input logic ret,
    input logic branch,
    input logic increment
  );
    pc_op_t op;
    if (load)           op = OP_LOAD;
    else if (call)      op = OP_CALL;
    else if (ret)       op = OP_RET;
    else if (branch)    op = OP_BRANCH;
    else if (increment) op = OP_INC;
    else                op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO. State advances on the falling clock edge to match the
// fetch datapath. A push while full or a pop while empty is ignored here; the
// owner of the stack decides what such an attempt means.
module return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int DW   = depth_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    depth_q;
  logic [DW-1:0]    depth_d;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  // Occupancy decodes; the entry below the count is the top of stack.
  always_comb begin
    full    = (depth_q == DW'(DEPTH));
    empty   = (depth_q == '0);
    wr_idx  = depth_q[AW-1:0];
    top_idx = AW'(depth_q - DW'(1));
    top     = mem_q[top_idx];
    depth   = depth_q;
  end

  // Next occupancy; push has precedence if both are ever raised together.
  always_comb begin
    depth_d = depth_q;
    wr_en   = 1'b0;
    if (push && !full) begin
      depth_d = depth_q + DW'(1);
      wr_en   = 1'b1;
    end else if (pop && !empty) begin
      depth_d = depth_q - DW'(1);
    end
  end

  // Occupancy register with synchronous active-low reset.
  always_ff @(negedge clk) begin
    if (!rst_n) depth_q <= '0;
    else        depth_q <= depth_d;
  end

  // Entry storage; contents are don't-care after reset so they are not cleared.
  always_ff @(negedge clk) begin
    if (rst_n && wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with relative branch, hardware call/return and sticky
// stack-error flags. All state updates on the falling edge of clk.
// Build option: define PC_TRAP_EN to redirect a failing call/ret to
// TRAP_VECTOR instead of the normal target.
//
// Control contract: there is no handshake. Every falling edge consumes the
// control inputs present at that moment, exactly one action (the highest
// priority one) takes effect, and its result is visible on the outputs
// immediately after that edge.
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(16'h7FF0),
  localparam int              DW           = depth_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_value,
  input  logic [WIDTH-1:0] offset,
  input  logic             load,
  input  logic             call,
  input  logic             ret,
  input  logic             branch,
  input  logic             increment,
  input  logic             clear_err,
  output logic [WIDTH-1:0] out,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  pc_op_t           op;
  logic [WIDTH-1:0] out_q, out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             stk_push, stk_pop;
  logic             ovf_hit, unf_hit;
  logic [WIDTH-1:0] stk_top;
  logic [WIDTH-1:0] ret_addr;
  logic             stk_full, stk_empty;
  logic [DW-1:0]    stk_depth;

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (ret_addr),
    .top       (stk_top),
    .depth     (stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Pick the winning action and compute next PC, stack request and error hits.
  always_comb begin
    op       = pc_decode(load, call, ret, branch, increment);
    out_d    = out_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    ovf_hit  = 1'b0;
    unf_hit  = 1'b0;
    ret_addr = out_q + WIDTH'(1);
    case (op)
      OP_LOAD: out_d = in_value;
      OP_CALL: begin
        if (stk_full) begin
          ovf_hit = 1'b1;
          out_d   = TRAP_EN ? TRAP_VECTOR : in_value;
        end else begin
          stk_push = 1'b1;
          out_d    = in_value;
        end
      end
      OP_RET: begin
        if (stk_empty) begin
          unf_hit = 1'b1;
          if (TRAP_EN) out_d = TRAP_VECTOR;
        end else begin
          stk_pop = 1'b1;
          out_d   = stk_top;
        end
      end
      OP_BRANCH: out_d = out_q + offset;
      OP_INC:    out_d = out_q + WIDTH'(1);
      default:   out_d = out_q;
    endcase
    // A new error in the same cycle as clear_err keeps its flag set.
    overflow_d  = (overflow_q  & ~clear_err) | ovf_hit;
    underflow_d = (underflow_q & ~clear_err) | unf_hit;
  end

  // PC and sticky flag registers with synchronous active-low reset.
  always_ff @(negedge clk) begin
    if (!reset) begin
      out_q       <= RESET_VECTOR;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Output drive.
  always_comb begin
    out       = out_q;
    depth     = stk_depth;
    full      = stk_full;
    empty     = stk_empty;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack (default parameters).
// Inputs change just after the rising edge, the DUT acts on the falling edge,
// and the monitor samples on the following rising edge.
module tb_program_counter_stack;

  localparam int          WIDTH = 16;
  localparam int          DEPTH = 8;
  localparam int          DW    = 4;
  localparam logic [15:0] RV    = 16'h0000;
  localparam logic [15:0] TV    = 16'h7FF0;
  localparam int          EW    = WIDTH + DW + 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] in_value = '0;
  logic [WIDTH-1:0] offset = '0;
  logic             load = 1'b0, call = 1'b0, ret = 1'b0;
  logic             branch = 1'b0, increment = 1'b0, clear_err = 1'b0;
  logic [WIDTH-1:0] out;
  logic [DW-1:0]    depth;
  logic             full, empty, overflow, underflow;

  program_counter_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_value  (in_value),
    .offset    (offset),
    .load      (load),
    .call      (call),
    .ret       (ret),
    .branch    (branch),
    .increment (increment),
    .clear_err (clear_err),
    .out       (out),
    .depth     (depth),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: PC, a queue used as the return stack, sticky flags.
  logic [15:0] m_pc = RV;
  logic [15:0] m_stk[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic trap_on();
`ifdef PC_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Apply one cycle of the documented rules to the model.
  task automatic model_step(input logic rst, ld, cl, rt, br, inc, ce,
                            input logic [15:0] iv, off);
    logic eo, eu;
    eo = 1'b0;
    eu = 1'b0;
    if (!rst) begin
      m_pc = RV;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (ld) m_pc = iv;
      else if (cl) begin
        if (m_stk.size() == DEPTH) begin
          eo = 1'b1;
          m_pc = trap_on() ? TV : iv;
        end else begin
          m_stk.push_back(16'(m_pc + 16'd1));
          m_pc = iv;
        end
      end else if (rt) begin
        if (m_stk.size() == 0) begin
          eu = 1'b1;
          if (trap_on()) m_pc = TV;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (br) m_pc = 16'(m_pc + off);
      else if (inc)    m_pc = 16'(m_pc + 16'd1);
      if (ce) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (eo) m_ovf = 1'b1;
      if (eu) m_unf = 1'b1;
    end
  endtask

  // Driver: present one cycle of controls and queue the expected result.
  task automatic drive(input logic rst, ld, cl, rt, br, inc, ce,
                       input logic [15:0] iv, off);
    @(posedge clk);
    #1;
    reset = rst; load = ld; call = cl; ret = rt; branch = br;
    increment = inc; clear_err = ce; in_value = iv; offset = off;
    model_step(rst, ld, cl, rt, br, inc, ce, iv, off);
    exp_q.push_back({m_pc, DW'(m_stk.size()), m_stk.size() == DEPTH,
                     m_stk.size() == 0, m_ovf, m_unf});
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
  endtask
  task automatic do_inc();
    drive(1, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
  endtask
  task automatic do_load(input logic [15:0] v);
    drive(1, 1, 0, 0, 0, 0, 0, v, 16'h0);
  endtask
  task automatic do_call(input logic [15:0] v);
    drive(1, 0, 1, 0, 0, 0, 0, v, 16'h0);
  endtask
  task automatic do_ret();
    drive(1, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0);
  endtask
  task automatic do_branch(input logic [15:0] o);
    drive(1, 0, 0, 0, 1, 0, 0, 16'h0, o);
  endtask
  task automatic do_clear();
    drive(1, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
  endtask

  // Monitor: on each rising edge, compare outputs against the oldest expectation.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out !== e[EW-1 -: WIDTH]) begin
          errors++;
          $display("FAIL out: got %h expected %h at %0t", out, e[EW-1 -: WIDTH], $time);
        end
        checks++;
        if (depth !== e[DW+3:4]) begin
          errors++;
          $display("FAIL depth: got %0d expected %0d at %0t", depth, e[DW+3:4], $time);
        end
        checks++;
        if ({full, empty} !== e[3:2]) begin
          errors++;
          $display("FAIL full_empty: got %b expected %b at %0t", {full, empty}, e[3:2], $time);
        end
        checks++;
        if ({overflow, underflow} !== e[1:0]) begin
          errors++;
          $display("FAIL flags: got %b expected %b at %0t", {overflow, underflow}, e[1:0], $time);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int wait_cycles;
    // 1: reset then three increments
    do_reset();
    repeat (3) do_inc();
    // 2: nested call/return
    do_load(16'h0010);
    do_call(16'h0100);
    do_call(16'h0200);
    do_ret();
    do_ret();
    // 3: fill the stack, overflow, clear
    do_reset();
    for (int i = 0; i < 9; i++) do_call(16'($urandom_range(0, 16'hFFFF)));
    do_clear();
    // clear_err together with a fresh overflow keeps the flag set
    drive(1, 0, 1, 0, 0, 0, 1, 16'h0ABC, 16'h0);
    do_clear();
    // 4: underflow at 0x0042
    do_reset();
    do_load(16'h0042);
    do_ret();
    do_clear();
    // 5: negative branch and increment wrap
    do_load(16'h0005);
    do_branch(16'hFFFD);
    do_load(16'hFFFF);
    do_inc();
    // 6: priority, then reset mid-stack
    drive(1, 1, 1, 0, 0, 1, 0, 16'h1234, 16'h0);
    do_call(16'h2000);
    do_call(16'h3000);
    do_call(16'h4000);
    drive(0, 1, 1, 1, 1, 1, 1, 16'h5555, 16'h0003);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, ld, cl, rt, br, inc, ce;
      r   = ($urandom_range(0, 59) != 0);
      ld  = ($urandom_range(0, 9) == 0);
      cl  = ($urandom_range(0, 2) == 0);
      rt  = ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 3) == 0);
      inc = ($urandom_range(0, 1) == 0);
      ce  = ($urandom_range(0, 7) == 0);
      drive(r, ld, cl, rt, br, inc, ce, 16'($urandom()), 16'($urandom()));
    end
    do_inc();
    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
